// File: rtl/cap_regctrl_mc.sv
// Multi-channel capture register controller: per-channel CAPADDR/CAPCTRL/CAPINT/CAPFIFO/FRAMECNT
// windows plus a global IRQ summary page, with one-shot capture and a registered interrupt line.
module cap_regctrl_mc #(
    parameter int         NCH  = 2,
    parameter logic [3:0] BASE = 4'h1
) (
    input  logic              i_aclk,
    input  logic              i_arst,
    input  logic [NCH-1:0]    i_cam_vsync,
    input  logic [NCH-1:0]    i_found_href,
    input  logic [NCH-1:0]    i_fifoover,
    input  logic [NCH-1:0]    i_fifounder,
    input  logic [15:0]       i_wraddr,
    input  logic [3:0]        i_byteen,
    input  logic              i_wren,
    input  logic [31:0]       i_wdata,
    input  logic [15:0]       i_rdaddr,
    input  logic              i_rden,
    output logic [31:0]       o_rdata,
    output logic [32*NCH-1:0] o_capaddr,
    output logic [NCH-1:0]    o_capon,
    output logic              o_cap_irq
);
    logic [NCH-1:0] r_prev_vs, r_capon, r_cblank, r_oneshot, r_armed;
    logic [NCH-1:0] r_frm_en, r_frm_st, r_err_en, r_err_st, r_under, r_over;
    logic [31:0]    r_capaddr  [NCH];
    logic [7:0]     r_ovcnt    [NCH];
    logic [15:0]    r_framecnt [NCH];
    logic [31:0]    r_rdata;
    logic           r_cap_irq;

    logic [NCH-1:0] w_vs_rise, w_irq_vec;
    logic [NCH-1:0] w_we_addr, w_we_ctrl, w_we_int, w_we_fifo, w_we_ovclr, w_we_fcnt;
    logic [31:0]    w_wdata_al, w_rd_val;
    logic           w_wr_hit;
    logic           w_unused;

    assign w_vs_rise  = i_cam_vsync & ~r_prev_vs;
    assign w_irq_vec  = (r_frm_en & r_frm_st) | (r_err_en & r_err_st);
    assign w_wdata_al = {i_wdata[31:3], 3'b000};
    assign w_wr_hit   = i_wren && (i_wraddr[15:12] == BASE);
    assign w_unused   = ^{i_wraddr[1:0], i_rdaddr[1:0]};

    always_comb begin
        w_we_addr  = '0;
        w_we_ctrl  = '0;
        w_we_int   = '0;
        w_we_fifo  = '0;
        w_we_ovclr = '0;
        w_we_fcnt  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_wr_hit && (i_wraddr[11:8] == 4'(c))) begin
                w_we_addr[c]  = (i_wraddr[7:2] == 6'h00);
                w_we_ctrl[c]  = (i_wraddr[7:2] == 6'h01) && i_byteen[0];
                w_we_int[c]   = (i_wraddr[7:2] == 6'h02) && i_byteen[0];
                w_we_fifo[c]  = (i_wraddr[7:2] == 6'h03) && i_byteen[0];
                w_we_ovclr[c] = (i_wraddr[7:2] == 6'h03) && i_byteen[1];
                w_we_fcnt[c]  = (i_wraddr[7:2] == 6'h04) && i_byteen[0];
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (i_rdaddr[15:12] == BASE) begin
            if (i_rdaddr[11:8] == 4'hF) begin
                if (i_rdaddr[7:2] == 6'h00) w_rd_val[NCH-1:0] = w_irq_vec;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (i_rdaddr[11:8] == 4'(c)) begin
                        case (i_rdaddr[7:2])
                            6'h00:   w_rd_val = r_capaddr[c];
                            6'h01:   w_rd_val = {29'd0, r_oneshot[c], r_cblank[c], r_capon[c]};
                            6'h02:   w_rd_val = {28'd0, r_err_st[c], r_err_en[c],
                                                 r_frm_st[c], r_frm_en[c]};
                            6'h03:   w_rd_val = {16'd0, r_ovcnt[c], 6'd0, r_over[c], r_under[c]};
                            6'h04:   w_rd_val = {16'd0, r_framecnt[c]};
                            default: w_rd_val = '0;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_arst) begin
            // prev starts high so a VSYNC held through reset produces no edge
            r_prev_vs <= '1;
            r_capon   <= '0;
            r_cblank  <= '0;
            r_oneshot <= '0;
            r_armed   <= '0;
            r_frm_en  <= '0;
            r_frm_st  <= '0;
            r_err_en  <= '0;
            r_err_st  <= '0;
            r_under   <= '0;
            r_over    <= '0;
            r_rdata   <= '0;
            r_cap_irq <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_capaddr[c]  <= '0;
                r_ovcnt[c]    <= '0;
                r_framecnt[c] <= '0;
            end
        end else begin
            r_prev_vs <= i_cam_vsync;
            r_cap_irq <= |w_irq_vec;
            if (i_rden) r_rdata <= w_rd_val;
            for (int c = 0; c < NCH; c++) begin
                if (w_we_addr[c]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_byteen[b]) r_capaddr[c][8*b +: 8] <= w_wdata_al[8*b +: 8];
                    end
                end

                // One-shot auto-clear first; a same-cycle software CAPCTRL write overrides it
                if (w_vs_rise[c] && r_oneshot[c]) begin
                    if (r_armed[c]) begin
                        r_capon[c] <= 1'b0;
                        r_armed[c] <= 1'b0;
                    end else if (r_capon[c]) begin
                        r_armed[c] <= 1'b1;
                    end
                end
                if (w_we_ctrl[c]) begin
                    r_capon[c]   <= i_wdata[0];
                    r_oneshot[c] <= i_wdata[2];
                    if (i_wdata[0]) r_armed[c] <= 1'b0;
                end

                if (w_vs_rise[c] && i_found_href[c]) r_cblank[c] <= 1'b1;
                else if (w_we_ctrl[c] && i_wdata[1]) r_cblank[c] <= 1'b0;

                if (w_we_int[c]) begin
                    r_frm_en[c] <= i_wdata[0];
                    r_err_en[c] <= i_wdata[2];
                end
                if (w_vs_rise[c]) r_frm_st[c] <= 1'b1;
                else if (w_we_int[c] && i_wdata[1]) r_frm_st[c] <= 1'b0;
                if (i_fifoover[c] || i_fifounder[c]) r_err_st[c] <= 1'b1;
                else if (w_we_int[c] && i_wdata[3]) r_err_st[c] <= 1'b0;

                if (i_fifounder[c]) r_under[c] <= 1'b1;
                else if (w_we_fifo[c] && i_wdata[0]) r_under[c] <= 1'b0;
                if (i_fifoover[c]) r_over[c] <= 1'b1;
                else if (w_we_fifo[c] && i_wdata[1]) r_over[c] <= 1'b0;

                if (w_we_ovclr[c]) r_ovcnt[c] <= {7'd0, i_fifoover[c]};
                else if (i_fifoover[c] && (r_ovcnt[c] != 8'hFF)) r_ovcnt[c] <= r_ovcnt[c] + 8'd1;

                if (w_we_fcnt[c]) r_framecnt[c] <= '0;
                else if (w_vs_rise[c] && r_capon[c]) r_framecnt[c] <= r_framecnt[c] + 16'd1;
            end
        end
    end

    always_comb begin
        o_capaddr = '0;
        for (int c = 0; c < NCH; c++) o_capaddr[32*c +: 32] = r_capaddr[c];
    end

    assign o_rdata   = r_rdata;
    assign o_capon   = r_capon;
    assign o_cap_irq = r_cap_irq;
endmodule

// File: tb/tb_cap_regctrl_mc.sv
// Self-checking bench for cap_regctrl_mc: scenario tasks with randomized stimulus checked
// against expectations computed from register semantics (byte merges, counts, saturation).
module tb_cap_regctrl_mc;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              arst;
    logic [NCH-1:0]    vsync, href, fover, funder;
    logic [15:0]       wraddr, rdaddr;
    logic [3:0]        byteen;
    logic              wren, rden;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [32*NCH-1:0] capaddr;
    logic [NCH-1:0]    capon;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_capaddr [NCH];

    cap_regctrl_mc #(.NCH(NCH), .BASE(4'h1)) dut (
        .i_aclk(clk), .i_arst(arst), .i_cam_vsync(vsync), .i_found_href(href),
        .i_fifoover(fover), .i_fifounder(funder), .i_wraddr(wraddr), .i_byteen(byteen),
        .i_wren(wren), .i_wdata(wdata), .i_rdaddr(rdaddr), .i_rden(rden), .o_rdata(rdata),
        .o_capaddr(capaddr), .o_capon(capon), .o_cap_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] ad(input int ch, input int off);
        ad = {4'h1, 4'(ch), 8'(off)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        wraddr = a; byteen = be; wdata = d; wren = 1'b1;
        tick(1);
        wren = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        rdaddr = a; rden = 1'b1;
        tick(1);
        rden = 1'b0;
        d = rdata;
    endtask

    task automatic vs_pulse(input int ch);
        vsync[ch] = 1'b1;
        tick(2);
        vsync[ch] = 1'b0;
        tick(2);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        merge = r & 32'hFFFF_FFF8;
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        vsync = '1; href = '0; fover = '0; funder = '0;
        wren = 0; rden = 0; wraddr = 0; rdaddr = 0; byteen = 0; wdata = 0;
        arst = 1'b1;
        tick(3);
        arst = 1'b0;
        tick(10);
        n_checks++;
        if (capon !== '0 || capaddr !== '0 || irq !== 1'b0 || rdata !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: capon=%h capaddr=%h irq=%b rdata=%h want all 0",
                     capon, capaddr, irq, rdata);
        end
        rd(ad(0, 'h10), d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_framecnt: got %h want 0", d); end
        rd(ad(0, 'h08), d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_no_edge: CAPINT %h want 0", d); end
        vsync = '0;
        tick(2);
        for (int c = 0; c < NCH; c++) m_capaddr[c] = '0;
    endtask

    task automatic test_capaddr;
        logic [31:0] d, v;
        logic [3:0] be;
        int ch;
        wr(ad(1, 'h00), 4'b0011, 32'h1234_5677);
        m_capaddr[1] = merge(m_capaddr[1], 4'b0011, 32'h1234_5677);
        rd(ad(1, 'h00), d);
        n_checks++;
        if (d !== 32'h0000_5670) begin
            n_errors++; $display("FAIL capaddr_partial: got %h want 00005670", d);
        end
        n_checks++;
        if (capaddr[63:32] !== 32'h0000_5670) begin
            n_errors++; $display("FAIL capaddr_port: got %h want 00005670", capaddr[63:32]);
        end
        for (int i = 0; i < 8; i++) begin
            ch = $urandom_range(0, NCH - 1);
            be = 4'($urandom);
            v = $urandom;
            wr(ad(ch, 'h00), be, v);
            m_capaddr[ch] = merge(m_capaddr[ch], be, v);
            rd(ad(ch, 'h00), d);
            n_checks++;
            if (d !== m_capaddr[ch] || capaddr[32*ch +: 32] !== m_capaddr[ch]) begin
                n_errors++;
                $display("FAIL capaddr_rand: ch%0d read %h port %h want %h", ch, d,
                         capaddr[32*ch +: 32], m_capaddr[ch]);
            end
        end
    endtask

    task automatic test_frame;
        logic [31:0] d;
        int k, m;
        wr(ad(0, 'h08), 4'b0001, 32'h1);
        wr(ad(0, 'h04), 4'b0001, 32'h1);
        vsync[0] = 1'b1;
        tick(1);
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_early: got %b want 0", irq); end
        tick(1);
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_frame: got %b want 1", irq); end
        vsync[0] = 1'b0;
        tick(2);
        vs_pulse(0);
        vs_pulse(0);
        rd(ad(0, 'h10), d);
        n_checks++;
        if (d !== 32'd3) begin n_errors++; $display("FAIL framecnt3: got %h want 3", d); end
        rd(ad(0, 'h08), d);
        n_checks++;
        if (d !== 32'h3) begin n_errors++; $display("FAIL capint_st: got %h want 3", d); end
        rd(ad(15, 'h00), d);
        n_checks++;
        if (d !== 32'h1) begin n_errors++; $display("FAIL irqsum: got %h want 1", d); end
        wr(ad(0, 'h08), 4'b0001, 32'h3);
        tick(1);
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        // Counting only happens while CAPON is high
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++) vs_pulse(0);
        wr(ad(0, 'h04), 4'b0001, 32'h0);
        m = $urandom_range(1, 4);
        for (int i = 0; i < m; i++) vs_pulse(0);
        rd(ad(0, 'h10), d);
        n_checks++;
        if (d !== 32'(3 + k)) begin
            n_errors++; $display("FAIL framecnt_gated: got %0d want %0d", d, 3 + k);
        end
        wr(ad(0, 'h10), 4'b0001, 32'h0);
        rd(ad(0, 'h10), d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL framecnt_clr: got %h want 0", d); end
        wr(ad(0, 'h08), 4'b0001, 32'h2);
        wr(ad(0, 'h04), 4'b0001, 32'h1);
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        wr(ad(1, 'h10), 4'b0001, 32'h0);
        wr(ad(1, 'h04), 4'b0001, 32'h5);
        vsync[1] = 1'b1;
        tick(1);
        n_checks++;
        if (capon[1] !== 1'b1) begin n_errors++; $display("FAIL oneshot_e1: capon %b want 1", capon[1]); end
        vsync[1] = 1'b0;
        tick(3);
        n_checks++;
        if (capon[1] !== 1'b1) begin n_errors++; $display("FAIL oneshot_hold: capon %b want 1", capon[1]); end
        vsync[1] = 1'b1;
        tick(1);
        n_checks++;
        if (capon[1] !== 1'b0) begin n_errors++; $display("FAIL oneshot_e2: capon %b want 0", capon[1]); end
        vsync[1] = 1'b0;
        tick(2);
        vs_pulse(1);
        rd(ad(1, 'h10), d);
        n_checks++;
        if (d !== 32'd2) begin n_errors++; $display("FAIL oneshot_cnt: got %0d want 2", d); end
        href[1] = 1'b1;
        vs_pulse(1);
        href[1] = 1'b0;
        rd(ad(1, 'h04), d);
        n_checks++;
        if (d !== 32'h6) begin n_errors++; $display("FAIL cblank: CAPCTRL %h want 6", d); end
        wr(ad(1, 'h04), 4'b0001, 32'h2);
        rd(ad(1, 'h04), d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL cblank_clr: CAPCTRL %h want 0", d); end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        int n;
        fover[0] = 1'b1;
        tick(300);
        fover[0] = 1'b0;
        rd(ad(0, 'h0C), d);
        n_checks++;
        if (d !== 32'hFF02) begin n_errors++; $display("FAIL ovcnt_sat: got %h want ff02", d); end
        wr(ad(0, 'h0C), 4'b0010, 32'h0);
        n = $urandom_range(1, 40);
        for (int i = 0; i < n; i++) begin
            fover[0] = 1'b1;
            tick(1);
            fover[0] = 1'b0;
            tick($urandom_range(0, 2));
        end
        rd(ad(0, 'h0C), d);
        n_checks++;
        if (d !== ((32'(n) << 8) | 32'h2)) begin
            n_errors++; $display("FAIL ovcnt_rand: got %h want count %0d with OVER", d, n);
        end
        fover[0] = 1'b1;
        wr(ad(0, 'h0C), 4'b0011, 32'h2);
        fover[0] = 1'b0;
        rd(ad(0, 'h0C), d);
        n_checks++;
        if (d !== 32'h0102) begin n_errors++; $display("FAIL ovcnt_race: got %h want 0102", d); end
        wr(ad(0, 'h08), 4'b0001, 32'hC);
        tick(2);
        funder[0] = 1'b1;
        tick(1);
        funder[0] = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin n_errors++; $display("FAIL err_irq_early: got %b want 0", irq); end
        tick(1);
        n_checks++;
        if (irq !== 1'b1) begin n_errors++; $display("FAIL err_irq: got %b want 1", irq); end
        rd(ad(0, 'h0C), d);
        n_checks++;
        if (d[0] !== 1'b1) begin n_errors++; $display("FAIL under_sticky: got %h want bit0=1", d); end
        wr(ad(0, 'h08), 4'b0001, 32'h8);
    endtask

    task automatic test_priority;
        logic [31:0] d, v;
        vsync[0] = 1'b1;
        wr(ad(0, 'h08), 4'b0001, 32'h2);
        vsync[0] = 1'b0;
        rd(ad(0, 'h08), d);
        n_checks++;
        if (d[1] !== 1'b1) begin n_errors++; $display("FAIL frm_st_race: CAPINT %h want bit1=1", d); end
        rd(ad(3, 'h00), d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL bad_channel: got %h want 0", d); end
        wr(ad(3, 'h00), 4'hF, 32'hFFFF_FFFF);
        rd(ad(2, 'h00), d);
        n_checks++;
        if (d !== 32'h0 || capaddr !== {m_capaddr[1], m_capaddr[0]}) begin
            n_errors++; $display("FAIL ignored_write: rd %h capaddr %h", d, capaddr);
        end
        v = $urandom;
        wraddr = ad(0, 'h00); byteen = 4'hF; wdata = v; wren = 1'b1;
        rdaddr = ad(0, 'h00); rden = 1'b1;
        tick(1);
        wren = 1'b0; rden = 1'b0;
        n_checks++;
        if (rdata !== m_capaddr[0]) begin
            n_errors++; $display("FAIL rw_same: got %h want old %h", rdata, m_capaddr[0]);
        end
        m_capaddr[0] = merge(m_capaddr[0], 4'hF, v);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        int ch;
        for (int i = 0; i < 6; i++) begin
            ch = i % NCH;
            v = $urandom;
            wraddr = ad(ch, 'h00); byteen = 4'hF; wdata = v; wren = 1'b1;
            tick(1);
            m_capaddr[ch] = merge(m_capaddr[ch], 4'hF, v);
        end
        wren = 1'b0;
        for (int i = 0; i < 2 * NCH; i++) begin
            ch = i % NCH;
            rdaddr = ad(ch, 'h00); rden = 1'b1;
            tick(1);
            n_checks++;
            if (rdata !== m_capaddr[ch]) begin
                n_errors++; $display("FAIL b2b_read: ch%0d got %h want %h", ch, rdata, m_capaddr[ch]);
            end
        end
        rden = 1'b0;
        tick(2);
        n_checks++;
        if (rdata !== m_capaddr[(2 * NCH - 1) % NCH]) begin
            n_errors++; $display("FAIL rdata_hold: got %h", rdata);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] d;
        wr(ad(0, 'h04), 4'b0001, 32'h1);
        vsync = '1;
        tick(1);
        arst = 1'b1;
        tick(1);
        arst = 1'b0;
        tick(3);
        n_checks++;
        if (capon !== '0 || capaddr !== '0 || irq !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: capon %h capaddr %h irq %b", capon, capaddr, irq);
        end
        rd(ad(0, 'h08), d);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL mid_reset_edge: CAPINT %h want 0", d); end
        vsync = '0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_capaddr();
        test_frame();
        test_oneshot();
        test_overrun();
        test_priority();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cap_regctrl_mc.md
# cap_regctrl_mc

Multi-channel register controller for the capture path. Each of NCH camera channels gets its own register window covering capture address, control, interrupt, FIFO status and frame count, plus a global interrupt summary. The block sits between the register bus decoder and the per-channel capture/VRAM writers. It drives each channel's CAPADDR and CAPON and one combined interrupt line. It generalises the single-channel controller and adds:
- per-source interrupts,
- one-shot capture,
- a saturating overrun counter,
- a frame counter.

## Interface
Parameters:
- NCH, 2: number of channels, legal range 1..4.
- BASE, 4'h1: value of address bits [15:12] that selects this block.

Ports:
- ACLK  in  1  clock; single clock domain.
- ARST  in  1  reset; synchronous, active-high.
- CAM_VSYNC  in  NCH  per-channel VSYNC, already synchronised to ACLK.
- FOUND_HREF  in  NCH  per-channel "HREF seen in current frame".
- FIFOOVER  in  NCH  per-channel FIFO overflow pulse.
- FIFOUNDER  in  NCH  per-channel FIFO underflow pulse.
- WRADDR  in  16  write byte address.
- BYTEEN  in  4  write byte enables.
- WREN  in  1  write strobe.
- WDATA  in  32  write data.
- RDADDR  in  16  read byte address.
- RDEN  in  1  read strobe.
- RDATA  out  32  registered read data.
- CAPADDR  out  32*NCH  channel c occupies bits [32c+31:32c].
- CAPON  out  NCH  capture enable per channel.
- CAP_IRQ  out  1  registered OR of all pending, enabled interrupts.

## Operation
Address decode:
- Access is valid when addr[15:12]==BASE.
- Channel = addr[11:8]; it must be < NCH.
- Register = addr[7:2].
- addr[11:8]==4'hF selects the global page.

Per-channel registers:
- 0x00 CAPADDR, R/W.
  - 32 bits; each byte written only where its BYTEEN bit is set.
  - Bits [2:0] always read 0 (8-byte alignment).
- 0x04 CAPCTRL.
  - bit0 CAPON, R/W.
  - bit1 CBLANK: sticky; set on a VSYNC rising edge when FOUND_HREF=1; write-1-to-clear.
  - bit2 ONESHOT, R/W.
- 0x08 CAPINT.
  - bit0 FRM_EN, R/W.
  - bit1 FRM_ST: set on every VSYNC rising edge; write-1-to-clear.
  - bit2 ERR_EN, R/W.
  - bit3 ERR_ST: set on FIFOOVER or FIFOUNDER; write-1-to-clear.
- 0x0C CAPFIFO.
  - bit0 UNDER, sticky; write-1-to-clear.
  - bit1 OVER, sticky; write-1-to-clear.
  - bits[15:8] OVCNT: counts FIFOOVER pulses, saturates at 255; cleared by any write to this register with BYTEEN[1] set.
- 0x10 FRAMECNT.
  - bits[15:0]: count of VSYNC rising edges while CAPON=1; wraps 0xFFFF->0.
  - Any write with BYTEEN[0] set clears it.

Global page:
- 0x00 IRQSUM (read-only). Bit c = (FRM_EN & FRM_ST) | (ERR_EN & ERR_ST) for channel c. Bits >= NCH read 0.

Access rules:
- Bit-field writes (CAPCTRL, CAPINT, CAPFIFO) require BYTEEN[0], except OVCNT clear, which requires BYTEEN[1].
- Writes to unmapped addresses or to channels >= NCH are ignored.

VSYNC edge detection:
- vs_rise[c] = CAM_VSYNC[c] & ~prev[c].
- prev resets to all ones, so VSYNC held high through reset produces no edge.

One-shot capture (ONESHOT=1):
- Software setting CAPON also clears the channel's armed flag.
- The first vs_rise with CAPON=1 sets armed.
- The next vs_rise with armed=1 clears CAPON and armed. Capture therefore covers exactly one full frame.
- ONESHOT=0: armed has no effect.

Simultaneous-event priority:
- Hardware set of CBLANK, FRM_ST, ERR_ST, UNDER or OVER beats a same-cycle write-1-to-clear.
- A software CAPON write beats the one-shot auto-clear.
- A FIFOOVER in the same cycle as an OVCNT clear leaves OVCNT=1.
- A FRAMECNT clear in the same cycle as an increment leaves FRAMECNT=0.

Reset values: all registers, RDATA, CAPADDR, CAPON, CAP_IRQ and armed are 0.

## Timing
- Register writes take effect on the ACLK edge on which WREN is sampled. CAPADDR and CAPON are visible on the next cycle.
- Read latency is 1 cycle:
  - RDEN at edge N gives RDATA valid after edge N.
  - RDATA holds its value until the next RDEN.
  - Unmapped reads return 0.
- vs_rise to status bit set: 1 cycle after the VSYNC sample.
- Status bit to CAP_IRQ: one further cycle, since CAP_IRQ is registered.
- An error pulse reaches CAP_IRQ 2 cycles after the pulse.
- ARST asserted mid-frame clears everything on that edge. A VSYNC still high at release produces no edge.
- Back-to-back writes and reads on consecutive cycles are fully supported. A read and a write to the same register in the same cycle return the pre-write value.

## Test plan
- Reset with CAM_VSYNC=all ones, then hold 10 cycles -> all outputs 0, FRAMECNT=0, CAP_IRQ=0.
- Write CAPADDR ch1 = 0x1234_5677 with BYTEEN=4'b0011, then read -> 0x0000_5670; CAPADDR[63:32] = 0x0000_5670.
- Ch0: FRM_EN=1, CAPON=1; pulse VSYNC 3 times -> FRAMECNT=3, FRM_ST=1, CAP_IRQ=1 two cycles after the first edge, IRQSUM=0x1. Write CAPINT=0x3 -> CAP_IRQ=0 next cycle.
- Ch1: ONESHOT=1, CAPON=1; VSYNC edges 1 and 2 -> CAPON stays 1 after edge 1 and is 0 one cycle after edge 2; FRAMECNT=2.
- 300 FIFOOVER pulses on ch0 -> OVCNT=255, OVER=1. Write CAPFIFO=0x2 with BYTEEN=4'b0011 concurrent with a FIFOOVER pulse -> OVER=1, OVCNT=1.
- FRM_ST write-1-to-clear in the same cycle as vs_rise -> FRM_ST remains 1. Read of channel 3 with NCH=2 -> RDATA=0.
